// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter slice: default widths,
// requester indices and the burst-counter width helper.
package dmem_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 16;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: both requesters' request
// fields plus the shared grant and read-return signals.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Two-way round-robin arbiter that lets the current owner keep the port for
// up to MAX_BURST consecutive grants while the other side is also asking.
module rr_burst_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    localparam int CW = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          last;
    logic [CW-1:0] cnt;
    logic          gnt_idx;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                // Owner keeps the port until its burst budget is spent.
                if (cnt < CNT_MAX) gnt = last ? 2'b10 : 2'b01;
                else               gnt = last ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    assign gnt_idx = gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b0;
            cnt  <= '0;
        end else if (gnt != 2'b00) begin
            if (gnt_idx == last) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            end else begin
                last <= gnt_idx;
                cnt  <= CNT_ONE;
            end
        end else begin
            // An idle cycle forfeits the burst already accumulated.
            cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one 1-cycle-latency single-port data memory between two requesters:
// per-cycle burst-limited round-robin grant, memory mux and read return.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         bus,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_do
);
    logic [1:0] gnt;
    logic [1:0] rd_pend;
    logic       sel;

    rr_burst_arbiter #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (bus.req),
        .gnt  (gnt)
    );

    // With no grant the mux falls back to requester 0 fields, but we stays low.
    assign sel      = gnt[REQ_DMA];
    assign mem_en   = |gnt;
    assign mem_we   = mem_en & (sel ? bus.we[REQ_DMA] : bus.we[REQ_CPU]);
    assign mem_addr = sel ? bus.addr1  : bus.addr0;
    assign mem_di   = sel ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 2'b00;
        else        rd_pend <= gnt & ~bus.we;
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rd_pend;
    assign bus.rdata  = mem_do;

endmodule
